// File: rtl/ahbl_stream_loader_pkg.sv
// rtl/ahbl_stream_loader_pkg.sv - shared AHB-Lite constants and loader state type
// Purpose: bus encodings and the FSM state enum shared by the loader and its packer.
package ahbl_stream_loader_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } loader_state_t;

endpackage

// File: rtl/ahbl_stream_loader_packer.sv
// rtl/ahbl_stream_loader_packer.sv - byte-to-word packer for the stream loader
// Purpose: collects four accepted bytes into one 32-bit word and flags completion.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clear_i          returns the byte index to lane 0 (held while the loader is idle)
//   byte_valid_i     a byte is accepted this cycle
//   byte_i           accepted byte
//   word_o           word including the byte accepted this cycle
//   word_done_o      this cycle's byte completes the word
// Macro STREAM_LOADER_BSWAP_EN: first byte lands in [31:24] instead of [7:0].
module stream_word_packer
    import ahbl_stream_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  idx_q;
    logic [1:0]  lane;
    logic [31:0] word_q;

`ifdef STREAM_LOADER_BSWAP_EN
    assign lane = 2'd3 - idx_q;
`else
    assign lane = idx_q;
`endif

    // word_o already contains the current byte so the loader can capture
    // the finished word in the same cycle the fourth byte arrives.
    always_comb begin
        word_o = word_q;
        if (byte_valid_i) begin
            word_o[{lane, 3'b000} +: 8] = byte_i;
        end
    end

    assign word_done_o = byte_valid_i && (idx_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear_i) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_valid_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/ahbl_stream_loader.sv
// rtl/ahbl_stream_loader.sv - AHB-Lite master writing a packed byte stream into SRAM
// Purpose: packs stream bytes into words and writes each one as a single
// NONSEQ word transfer at an incrementing address; reports done or err.
// Ports:
//   HCLK, HRESETn                      clock, asynchronous active-low reset
//   start, base_addr, word_count       job request (sampled only when idle)
//   s_tdata, s_tvalid, s_tready        byte stream sink
//   busy, done, err, words_written     job status
//   HADDR, HTRANS, HSIZE, HWRITE,
//   HWDATA, HREADY, HRESP              AHB-Lite master interface
// Macro STREAM_LOADER_BSWAP_EN: big-endian byte packing (see stream_word_packer).
module ahbl_stream_loader
    import ahbl_stream_loader_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int ADDR_ALIGN_CHK = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    loader_state_t    state_q;
    logic [31:0]      addr_q;
    logic [31:0]      hwdata_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] ww_q;
    logic [CNT_W-1:0] ww_inc;
    logic [1:0]       htrans_q;
    logic             hwrite_q;
    logic             tready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             byte_fire;
    logic             pack_clear;
    logic             word_done;
    logic [31:0]      word_next;
    logic             misaligned;

    assign byte_fire  = s_tvalid & tready_q;
    assign pack_clear = (state_q == ST_IDLE);
    assign misaligned = (ADDR_ALIGN_CHK != 0) && (base_addr[1:0] != 2'b00);
    assign ww_inc     = ww_q + CNT_W'(1);

    stream_word_packer u_packer (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .clear_i      (pack_clear),
        .byte_valid_i (byte_fire),
        .byte_i       (s_tdata),
        .word_o       (word_next),
        .word_done_o  (word_done)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            hwdata_q <= 32'd0;
            count_q  <= '0;
            ww_q     <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                        end else if (misaligned) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q   <= base_addr;
                            count_q  <= word_count;
                            ww_q     <= '0;
                            err_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            tready_q <= 1'b1;
                            state_q  <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (word_done) begin
                        hwdata_q <= word_next;
                        tready_q <= 1'b0;
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= 1'b1;
                        state_q  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        hwrite_q <= 1'b0;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // ERROR is acted on in its first (HREADY low) cycle; the
                    // slave's second response cycle then finds the bus idle.
                    if (HRESP == HRESP_ERROR) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (HREADY) begin
                        ww_q   <= ww_inc;
                        addr_q <= addr_q + 32'd4;
                        if (ww_inc == count_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            tready_q <= 1'b1;
                            state_q  <= ST_FILL;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_tready      = tready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = ww_q;
    assign HADDR         = addr_q;
    assign HTRANS        = htrans_q;
    assign HSIZE         = HSIZE_WORD;
    assign HWRITE        = hwrite_q;
    assign HWDATA        = hwdata_q;

endmodule

// File: tb/tb_ahbl_stream_loader.sv
// tb/tb_ahbl_stream_loader.sv - self-checking bench for ahbl_stream_loader
`timescale 1ns/1ps
module tb_ahbl_stream_loader;

    localparam int CNT_W = 16;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base_addr = 32'd0;
    logic [CNT_W-1:0] word_count = '0;
    logic [7:0]       s_tdata = 8'd0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             busy, done, err;
    logic [CNT_W-1:0] words_written;
    logic [31:0]      HADDR, HWDATA;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic             HWRITE;
    logic             HREADY = 1'b1;
    logic             HRESP = 1'b0;

    always #5 HCLK = ~HCLK;

    ahbl_stream_loader #(.CNT_W(CNT_W), .ADDR_ALIGN_CHK(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .busy(busy), .done(done), .err(err),
        .words_written(words_written), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    int n_vec = 0;
    int n_fail = 0;

    // slave / stream model state
    int cfg_aw, cfg_dw, cfg_err_at, cfg_vm;
    bit cfg_rw;
    bit dph, tog;
    int a_cnt, d_cnt, xfer_idx, dph_idx, cur_aw, cur_dw;
    int stab_err, bytes_acc;
    logic [31:0] a_addr, dph_addr, dph_data;
    logic [7:0]  src_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        logic [31:0] base;
        int          cnt;
        int          err_at;
        int          aw;
        int          dw;
        int          vm;
        bit          fixed;
        bit          exp_err;
        int          exp_ww;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
`ifdef STREAM_LOADER_BSWAP_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    // AHB slave + byte source, evaluated once per negedge for the coming posedge.
    task automatic bus_step();
        bit vld;
        if (!HRESETn) begin
            HREADY = 1'b1; HRESP = 1'b0; s_tvalid = 1'b0; s_tdata = 8'd0;
            return;
        end
        if (dph) begin
            if (d_cnt == 0) dph_data = HWDATA;
            else if (HWDATA !== dph_data) stab_err++;
            if (s_tready !== 1'b0 || HTRANS !== 2'b00) stab_err++;
            if (dph_idx == cfg_err_at) begin
                HRESP = 1'b1; HREADY = (d_cnt != 0);
            end else begin
                HRESP = 1'b0; HREADY = (d_cnt >= cur_dw);
            end
            if (HREADY) begin
                if (!HRESP) begin
                    wr_addr.push_back(dph_addr);
                    wr_data.push_back(HWDATA);
                end
                dph = 1'b0;
            end
            d_cnt++;
        end else if (HTRANS === 2'b10) begin
            if (a_cnt == 0) begin
                a_addr = HADDR;
                cur_aw = cfg_rw ? int'($urandom_range(0, 2)) : cfg_aw;
                cur_dw = cfg_rw ? int'($urandom_range(0, 2)) : cfg_dw;
            end else if (HADDR !== a_addr) stab_err++;
            if (HWRITE !== 1'b1 || HSIZE !== 3'b010 || s_tready !== 1'b0) stab_err++;
            HRESP = 1'b0;
            HREADY = (a_cnt >= cur_aw);
            if (HREADY) begin
                dph = 1'b1; d_cnt = 0; dph_addr = HADDR;
                dph_idx = xfer_idx; xfer_idx++; a_cnt = 0;
            end else a_cnt++;
        end else begin
            if (HTRANS !== 2'b00 || HWRITE !== 1'b0) stab_err++;
            HREADY = 1'b1; HRESP = 1'b0;
        end
        case (cfg_vm)
            0: vld = 1'b1;
            1: begin tog = ~tog; vld = tog; end
            default: vld = 1'($urandom_range(0, 1));
        endcase
        s_tvalid = vld && (src_q.size() > 0);
        s_tdata  = s_tvalid ? src_q[0] : 8'h00;
        if (s_tvalid && s_tready) begin
            void'(src_q.pop_front());
            bytes_acc++;
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        bus_step();
    endtask

    task automatic model_reset();
        dph = 1'b0; a_cnt = 0; d_cnt = 0; tog = 1'b0;
        src_q.delete();
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".ww"}, words_written, 0);
        chk({tag, ".haddr"}, HADDR, 0);
        chk({tag, ".htrans"}, HTRANS, 0);
        chk({tag, ".hsize"}, HSIZE, 3'b010);
        chk({tag, ".hwrite"}, HWRITE, 0);
        chk({tag, ".hwdata"}, HWDATA, 0);
        chk({tag, ".tready"}, s_tready, 0);
    endtask

    task automatic pulse_reset();
        #2 HRESETn = 1'b0;
        model_reset();
        tick();
        HRESETn = 1'b1;
    endtask

    task automatic run_job(string tag, logic [31:0] base, int cnt, int err_at, int aw, int dw,
                           int vm, bit rw, bit fixed, bit exp_err, int exp_ww);
        logic [7:0]  bytes[$];
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        bit ok_start, timed_out, seen_done, busy0;
        int cyc, exp_xfer, n;
        for (int i = 0; i < cnt * 4; i++)
            bytes.push_back(fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        ok_start = (cnt != 0) && (base[1:0] == 2'b00);
        exp_xfer = !ok_start ? 0 : (err_at >= 0 ? err_at + 1 : cnt);
        if (ok_start) begin
            for (int w = 0; w < cnt; w++) begin
                if (err_at >= 0 && w >= err_at) break;
                exp_a.push_back(base + 32'(4 * w));
                exp_d.push_back(pack(bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]));
            end
        end
        tick();
        cfg_aw = aw; cfg_dw = dw; cfg_err_at = err_at; cfg_vm = vm; cfg_rw = rw;
        xfer_idx = 0; stab_err = 0; tog = 1'b0;
        wr_addr.delete(); wr_data.delete();
        src_q = bytes;
        tick();
        start = 1'b1; base_addr = base; word_count = CNT_W'(cnt);
        timed_out = 1'b1;
        busy0 = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (cyc == 0) begin start = 1'b0; busy0 = busy; end
            if (done || err) begin timed_out = 1'b0; break; end
        end
        seen_done = done;
        tick();
        chk({tag, ".done_width"}, done, 0);
        for (int i = 0; i < 3; i++) tick();
        chk({tag, ".timeout"}, timed_out, 0);
        chk({tag, ".done"}, seen_done, !exp_err);
        chk({tag, ".err"}, err, exp_err);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".busy_start"}, busy0, ok_start);
        if (exp_ww >= 0) chk({tag, ".ww"}, words_written, exp_ww);
        chk({tag, ".nxfer"}, xfer_idx, exp_xfer);
        chk({tag, ".nwrites"}, wr_addr.size(), exp_a.size());
        n = (wr_addr.size() < exp_a.size()) ? wr_addr.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.addr%0d", tag, i), wr_addr[i], exp_a[i]);
            chk($sformatf("%s.data%0d", tag, i), wr_data[i], exp_d[i]);
        end
        chk({tag, ".stable"}, stab_err, 0);
        if (ok_start && aw == 0 && dw == 0 && !rw && vm == 0 && err_at < 0)
            chk({tag, ".latency"}, cyc, 6 * cnt);
        src_q.delete();
        if (timed_out) pulse_reset();
    endtask

    logic [31:0] lit0, lit1;
    int          cnt_r, err_r;

    initial begin
`ifdef STREAM_LOADER_BSWAP_EN
        lit0 = 32'h11223344; lit1 = 32'h55667788;
`else
        lit0 = 32'h44332211; lit1 = 32'h88776655;
`endif
        vecs[0] = '{32'h0000_0100, 2, -1, 0, 0, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{32'h0000_0200, 1, -1, 3, 2, 0, 1'b0, 1'b0, 1};
        vecs[2] = '{32'h0000_0300, 0, -1, 0, 0, 0, 1'b0, 1'b0, -1};
        vecs[3] = '{32'h0000_0102, 1, -1, 0, 0, 0, 1'b0, 1'b1, -1};
        vecs[4] = '{32'h0000_0110, 2, -1, 0, 0, 0, 1'b0, 1'b0, 2};
        vecs[5] = '{32'h0000_0400, 4,  1, 0, 1, 0, 1'b0, 1'b1, 1};
        vecs[6] = '{32'h0000_0500, 1, -1, 0, 0, 1, 1'b0, 1'b0, 1};
        vecs[7] = '{32'hFFFF_FFF8, 3, -1, 1, 0, 0, 1'b0, 1'b0, 3};

        cfg_aw = 0; cfg_dw = 0; cfg_err_at = -1; cfg_vm = 0; cfg_rw = 1'b0;
        xfer_idx = 0; stab_err = 0; bytes_acc = 0; dph_idx = 0;
        model_reset();
        #1 chk_reset_vals("por");
        repeat (3) tick();
        HRESETn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i].base, vecs[i].cnt, vecs[i].err_at,
                    vecs[i].aw, vecs[i].dw, vecs[i].vm, 1'b0, vecs[i].fixed,
                    vecs[i].exp_err, vecs[i].exp_ww);
            if (i == 0 && wr_data.size() >= 2) begin
                chk("vec0.lit0", wr_data[0], lit0);
                chk("vec0.lit1", wr_data[1], lit1);
            end
        end

        // reset after partial fill, then a fresh job must pack from lane 0
        tick();
        cfg_vm = 0; cfg_aw = 0; cfg_dw = 0; cfg_err_at = -1; cfg_rw = 1'b0;
        src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(8'hA0 + 8'(i));
        bytes_acc = 0;
        start = 1'b1; base_addr = 32'h700; word_count = CNT_W'(1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && bytes_acc < 3; i++) tick();
        chk("rst_fill.reached", bytes_acc >= 3, 1);
        #2 HRESETn = 1'b0;
        #1 chk_reset_vals("rst_fill");
        model_reset();
        tick();
        HRESETn = 1'b1;
        run_job("fresh", 32'h800, 1, -1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1);
        if (wr_data.size() >= 1) chk("fresh.lit", wr_data[0], lit0);

        // reset while the address phase is stalled: bus must go idle at once
        tick();
        cfg_aw = 20; src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
        start = 1'b1; base_addr = 32'h900; word_count = CNT_W'(1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && HTRANS !== 2'b10; i++) tick();
        chk("rst_addr.reached", HTRANS, 2'b10);
        #2 HRESETn = 1'b0;
        #1 chk_reset_vals("rst_addr");
        model_reset();
        tick();
        HRESETn = 1'b1;

        for (int j = 0; j < 16; j++) begin
            cnt_r = int'($urandom_range(1, 5));
            err_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt_r - 1)) : -1;
            run_job($sformatf("rnd%0d", j), $urandom & 32'hFFFF_FFFC, cnt_r, err_r, 0, 0, 2,
                    1'b1, 1'b0, err_r >= 0, (err_r >= 0) ? err_r : cnt_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
